// File: rtl/radio_pkg.sv
// Shared types and helpers for the radio capture path.
// States, default settle length and antenna word width.
package radio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_e;

  localparam int DEFAULT_SETTLE_CYCLES = 64;

  function automatic int ant_word_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/radio_sample_hold.sv
// One-entry valid/ready holding register for antenna words.
// Drops a new word when full and stalled, raising a sticky flag.
module radio_sample_hold #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         clr_ovf_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         ovf_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic         drop;

  always_comb begin
    drop    = load_i & valid_q & ~ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/radio_capture_ctrl.sv
// Capture-run sequencer: front-end reset, settle window,
// decimated sampling of radio or dummy sources into a stream.
module radio_capture_ctrl
  import radio_pkg::*;
#(
  parameter int NUM_ANT       = 24,
  parameter int CAP_LEN_W     = 16,
  parameter int DECIM_W       = 4,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                   clk16,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   src_sel,
  input  logic [CAP_LEN_W-1:0]   capture_len,
  input  logic [DECIM_W-1:0]     decim,
  input  logic [NUM_ANT-1:0]     radio_i,
  input  logic [NUM_ANT-1:0]     radio_q,
  input  logic [NUM_ANT-1:0]     dummy_i,
  input  logic [NUM_ANT-1:0]     dummy_q,
  output logic                   fe_rst_n,
  output logic [2*NUM_ANT-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [CAP_LEN_W-1:0]   sample_count
);

  localparam int WW = ant_word_w(NUM_ANT);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_e               state_q, state_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [DECIM_W-1:0]   dcnt_q, dcnt_d;
  logic [DECIM_W-1:0]   dcfg_q, dcfg_d;
  logic [CAP_LEN_W-1:0] len_q, len_d;
  logic [CAP_LEN_W-1:0] cnt_q, cnt_d;
  logic [CAP_LEN_W-1:0] cnt_inc;
  logic                 src_q, src_d;
  logic                 fe_q, fe_d;
  logic                 strobe, start_ok;
  logic [WW-1:0]        word;

  assign cnt_inc = cnt_q + CAP_LEN_W'(1);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    dcnt_d   = dcnt_q;
    dcfg_d   = dcfg_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    strobe   = 1'b0;
    start_ok = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          start_ok = 1'b1;
          src_d    = src_sel;
          len_d    = capture_len;
          dcfg_d   = decim;
          cnt_d    = '0;
          settle_d = SW'(SETTLE_CYCLES - 1);
          state_d  = SETTLE;
        end
        SETTLE: if (settle_q == '0) begin
          dcnt_d  = '0;
          state_d = (len_q == '0) ? DONE : CAPTURE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
        CAPTURE: if (dcnt_q == '0) begin
          strobe = 1'b1;
          dcnt_d = dcfg_q;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) state_d = DRAIN;
        end else begin
          dcnt_d = dcnt_q - DECIM_W'(1);
        end
        DRAIN: if (!out_valid) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // front-ends run only while a run is actively sequencing
    fe_d = (state_d == SETTLE) || (state_d == CAPTURE) ||
           (state_d == DRAIN);
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      dcnt_q   <= '0;
      dcfg_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      src_q    <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      dcnt_q   <= dcnt_d;
      dcfg_q   <= dcfg_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      fe_q     <= fe_d;
    end
  end

  assign word = src_q ? {dummy_q, dummy_i} : {radio_q, radio_i};

  radio_sample_hold #(.W(WW)) u_hold (
    .clk       (clk16),
    .rst_n     (rst_n),
    .flush_i   (abort),
    .clr_ovf_i (start_ok),
    .load_i    (strobe),
    .data_i    (word),
    .ready_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .ovf_o     (overflow)
  );

  assign fe_rst_n     = fe_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign sample_count = cnt_q;

endmodule
